dmem_pipe_ctrl: RTL and testbench
=================================

Name: dmem_pipe_ctrl

Overview:
- Parametrised successor to the single-cycle data-memory wrapper in the MEM stage of the rv32im pipeline.
- Adds configurable read latency, configurable depth and width, and byte-lane masking on both reads and writes.
- Adds a stall input that freezes the response pipeline, plus a per-response address tag for scoreboard matching.
- Sits between the MEM-stage load/store unit and the synchronous data RAM array, which is instantiated internally.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8. Byte lanes NB = DATA_W/8.
- ADDR_W, 8: word-address width. Array depth = DEPTH.
- DEPTH, 256: number of words; must be ≤ 2^ADDR_W.
- RD_LATENCY, 1: cycles from accepted read to valid; legal range 1..4.
- INIT_MEM, 0: 1 = preload array from hex file at elaboration; 0 = array contents undefined.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- request, input, 1: access request this cycle.
- we_re, input, 1: 1 = write, 0 = read.
- load, input, 1: read expects a response. A read with load=0 is a dummy (no valid is produced).
- mask, input, NB: byte-lane enables.
- address, input, ADDR_W: word address.
- data_in, input, DATA_W: write data.
- stall, input, 1: downstream stall; freezes the response pipeline.
- ready, output, 1: request will be accepted this cycle.
- valid, output, 1: data_out holds read response.
- data_out, output, DATA_W: read data, masked.
- resp_addr, output, ADDR_W: address of the read now on data_out.

Behaviour:
- Reset (rst=1 at clk edge): valid=0, data_out=0, resp_addr=0, all pipeline stage valids cleared. Array contents unchanged.
- ready = !stall && !rst (combinational). A request is accepted iff request && ready.
- Accepted write:
  - Byte lane i of address is written with data_in[8i+7:8i] at that edge iff mask[i]=1.
  - mask=0 is a legal no-op.
  - The write is visible to a read accepted on the next cycle.
- Accepted read with load=1:
  - Array read at the accepting edge.
  - Result enters a RD_LATENCY-deep shift pipeline carrying {valid, data, addr}.
  - valid=1 for exactly one cycle, RD_LATENCY cycles after acceptance (absent stalls).
  - data_out lane i = array byte if mask[i]=1, else 8'h00.
- Accepted read with load=0: array not read, no response.
- Back-to-back reads: one accepted per cycle; responses come out in order, one per cycle.
- stall=1:
  - No new acceptance.
  - All pipeline stages and outputs hold their values; valid stays asserted if it was 1.
  - A response is consumed only on a cycle with valid=1 && stall=0.
- Address ≥ DEPTH: write is dropped. Read returns all-zero data with valid still generated.
- Reset mid-flight: all in-flight reads are discarded, valid=0 from the next cycle. Writes accepted before the reset edge persist.
- request with rst=1 is ignored.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset 0.
  - err is pipelined alongside valid and asserted together with valid for an out-of-range read.
  - err also pulses for exactly one cycle, the cycle after acceptance, for an out-of-range write.
  - Out-of-range reads and writes behave as specified above.
- Undefined: no err port; out-of-range behaviour otherwise identical.

Test Plan:
1. RD_LATENCY=1: write 0xDEADBEEF to addr 5, mask 4'hF; read addr 5, mask 4'hF, load=1 next cycle -> one cycle later valid=1, data_out=0xDEADBEEF, resp_addr=5.
2. Byte masking: write 0x11223344 mask 4'hF to addr 9, then 0xAABBCCDD mask 4'b0101; read mask 4'b0011 -> data_out=0x000033DD.
3. RD_LATENCY=3: reads addrs 1,2,3 on consecutive cycles -> valid high for 3 consecutive cycles starting 3 cycles after the first, with data in order.
4. Stall: raise stall for 2 cycles while valid=1 -> ready=0, data_out and resp_addr held, valid held; a new request during stall is not executed.
5. Reset mid-flight: RD_LATENCY=2, assert rst one cycle after a read -> valid never rises; a prior write is still readable after reset.
6. DEPTH=200: write then read addr 210 -> array unchanged, read data 0, valid=1; with DMEM_ERR_EN, err=1 alongside that valid and a one-cycle err pulse after the write.

Source files
------------

// File: rtl/dmem_pipe_ctrl.sv
// MEM-stage data-memory controller: byte-masked RAM with a stallable, tagged read-response pipeline.
// Optional DMEM_ERR_EN adds an err output flagging out-of-range accesses.
module dmem_pipe_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned INIT_MEM   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     request,
    input  logic                     we_re,
    input  logic                     load,
    input  logic [DATA_W/8-1:0]      mask,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     stall,
    output logic                     ready,
    output logic                     valid,
    output logic [DATA_W-1:0]        data_out,
    output logic [ADDR_W-1:0]        resp_addr
`ifdef DMEM_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int unsigned NB = DATA_W / 8;

    logic              w_accept;
    logic              w_in_range;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_data;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_pv  [RD_LATENCY];
    logic [DATA_W-1:0] r_pd  [RD_LATENCY];
    logic [ADDR_W-1:0] r_pa  [RD_LATENCY];

    assign ready      = !stall && !rst;
    assign w_accept   = request && ready;
    assign w_in_range = 32'(address) < DEPTH;
    assign w_wr_fire  = w_accept && we_re && w_in_range;
    assign w_rd_fire  = w_accept && !we_re && load;

    // Byte-lane write; out-of-range writes never touch the array
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (mask[i]) begin
                    r_mem[address][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Array word with lane masking; out-of-range reads yield zero
    always_comb begin
        w_rd_word = '0;
        w_rd_data = '0;
        if (w_in_range) begin
            w_rd_word = r_mem[address];
        end
        for (int unsigned i = 0; i < NB; i++) begin
            if (mask[i]) begin
                w_rd_data[8*i +: 8] = w_rd_word[8*i +: 8];
            end
        end
    end

    // Response shift pipeline; the last stage drives the outputs and freezes on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                r_pv[k] <= 1'b0;
                r_pd[k] <= '0;
                r_pa[k] <= '0;
            end
        end else if (!stall) begin
            r_pv[0] <= w_rd_fire;
            r_pd[0] <= w_rd_fire ? w_rd_data : '0;
            r_pa[0] <= w_rd_fire ? address : '0;
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pd[k] <= r_pd[k-1];
                r_pa[k] <= r_pa[k-1];
            end
        end
    end

    assign valid     = r_pv[RD_LATENCY-1];
    assign data_out  = r_pd[RD_LATENCY-1];
    assign resp_addr = r_pa[RD_LATENCY-1];

`ifdef DMEM_ERR_EN
    logic r_pe [RD_LATENCY];
    logic r_err_wr;

    // Read errors ride the pipeline with their response; write errors pulse once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_wr <= 1'b0;
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                r_pe[k] <= 1'b0;
            end
        end else begin
            r_err_wr <= w_accept && we_re && !w_in_range;
            if (!stall) begin
                r_pe[0] <= w_rd_fire && !w_in_range;
                for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                    r_pe[k] <= r_pe[k-1];
                end
            end
        end
    end

    assign err = r_err_wr || r_pe[RD_LATENCY-1];
`endif

endmodule

// File: tb/tb_dmem_pipe_ctrl.sv
// Bench for dmem_pipe_ctrl: three instances (latency 1/2/3, depth 256/256/200) share one stimulus stream
// and are checked every cycle against a queue-based response model plus hand-computed literals.
module tb_dmem_pipe_ctrl;

    localparam int unsigned LATS [3] = '{1, 2, 3};
    localparam int unsigned DEPS [3] = '{256, 256, 200};

    logic        clk = 1'b0;
    logic        rst, request, we_re, load, stall;
    logic [3:0]  mask;
    logic [7:0]  address;
    logic [31:0] data_in;

    logic        rdy  [3];
    logic        vld  [3];
    logic [31:0] dout [3];
    logic [7:0]  radr [3];
`ifdef DMEM_ERR_EN
    logic        errv [3];
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_pipe_ctrl #(
            .DATA_W    (32),
            .ADDR_W    (8),
            .DEPTH     (DEPS[g]),
            .RD_LATENCY(LATS[g]),
            .INIT_MEM  (0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .request  (request),
            .we_re    (we_re),
            .load     (load),
            .mask     (mask),
            .address  (address),
            .data_in  (data_in),
            .stall    (stall),
            .ready    (rdy[g]),
            .valid    (vld[g]),
            .data_out (dout[g]),
            .resp_addr(radr[g])
`ifdef DMEM_ERR_EN
            ,
            .err      (errv[g])
`endif
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each response is due when the count of advancing (non-stall, non-reset) edges reaches a target
    typedef struct {
        int          inst;
        longint      due;
        logic [31:0] d;
        logic [7:0]  a;
        bit          e;
    } ent_t;

    ent_t        pend [$];
    longint      adv = 0;
    int          cyc = 0;
    int          wr_err_cyc [3] = '{-1, -1, -1};
    logic [31:0] mm [3][256];

    always @(posedge clk) begin : model
        ent_t        en;
        bit          inr;
        logic [31:0] w;
        cyc = cyc + 1;
        if (rst) begin
            pend.delete();
        end else if (!stall) begin
            adv = adv + 1;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due < adv) pend.delete(i);
            end
            if (request) begin
                for (int k = 0; k < 3; k++) begin
                    inr = 32'(address) < DEPS[k];
                    if (we_re) begin
                        if (inr) begin
                            for (int b = 0; b < 4; b++)
                                if (mask[b]) mm[k][address][8*b +: 8] = data_in[8*b +: 8];
                        end else begin
                            wr_err_cyc[k] = cyc;
                        end
                    end else if (load) begin
                        w = 32'h0;
                        if (inr) begin
                            for (int b = 0; b < 4; b++)
                                if (mask[b]) w[8*b +: 8] = mm[k][address][8*b +: 8];
                        end
                        en.inst = k;
                        en.due  = adv + longint'(LATS[k]) - 1;
                        en.d    = w;
                        en.a    = address;
                        en.e    = !inr;
                        pend.push_back(en);
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : compare
        bit          ev, ee;
        logic [31:0] ed;
        logic [7:0]  ea;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                ev = 1'b0; ee = 1'b0; ed = 32'h0; ea = 8'h0;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].inst == k && pend[i].due == adv) begin
                        ev = 1'b1; ed = pend[i].d; ea = pend[i].a; ee = pend[i].e;
                    end
                end
                chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!stall && !rst));
                chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(ev));
                if (ev) begin
                    chk($sformatf("data_out%0d", k), dout[k], ed);
                    chk($sformatf("resp_addr%0d", k), 32'(radr[k]), 32'(ea));
                end
`ifdef DMEM_ERR_EN
                chk($sformatf("err%0d", k), 32'(errv[k]), 32'(ee || (wr_err_cyc[k] == cyc)));
`endif
            end
        end
    end

    task automatic step(input bit r, input bit rq, input bit we, input bit ld,
                        input logic [3:0] m, input logic [7:0] a, input logic [31:0] d, input bit s);
        rst = r; request = rq; we_re = we; load = ld;
        mask = m; address = a; data_in = d; stall = s;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        step(0, 1, 1, 0, m, a, d, 0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [3:0] m);
        step(0, 1, 0, 1, m, a, 32'h0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        chk_en = 1'b1;
        step(1, 1, 0, 1, 4'hF, 8'h5, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'h0);
            chk($sformatf("rst_data%0d", k), dout[k], 32'h0);
            chk($sformatf("rst_addr%0d", k), 32'(radr[k]), 32'h0);
        end

        // Write then read, latency 1/2/3
        wr(8'd5, 32'hDEADBEEF, 4'hF);
        rd(8'd5, 4'hF);
        chk("t1_valid_l1", 32'(vld[0]), 32'h1);
        chk("t1_data_l1", dout[0], 32'hDEADBEEF);
        chk("t1_addr_l1", 32'(radr[0]), 32'd5);
        chk("t1_valid_l2_early", 32'(vld[1]), 32'h0);
        idle(1);
        chk("t1_valid_l1_drop", 32'(vld[0]), 32'h0);
        chk("t1_data_l2", dout[1], 32'hDEADBEEF);
        idle(1);
        chk("t1_valid_l3", 32'(vld[2]), 32'h1);
        chk("t1_addr_l3", 32'(radr[2]), 32'd5);
        idle(2);

        // Byte masking on write and read
        wr(8'd9, 32'h11223344, 4'hF);
        wr(8'd9, 32'hAABBCCDD, 4'b0101);
        rd(8'd9, 4'b0011);
        chk("t2_masked", dout[0], 32'h000033DD);
        idle(1);
        rd(8'd9, 4'b1100);
        chk("t2_masked_hi", dout[0], 32'h11BB0000);
        idle(3);

        // Back-to-back reads through the latency-3 pipe
        wr(8'd1, 32'h10000001, 4'hF);
        wr(8'd2, 32'h20000002, 4'hF);
        wr(8'd3, 32'h30000003, 4'hF);
        rd(8'd1, 4'hF);
        rd(8'd2, 4'hF);
        rd(8'd3, 4'hF);
        chk("t3_first_l3", dout[2], 32'h10000001);
        chk("t3_first_addr_l3", 32'(radr[2]), 32'd1);
        idle(1);
        chk("t3_second_l3", 32'(radr[2]), 32'd2);
        idle(1);
        chk("t3_third_l3", dout[2], 32'h30000003);
        idle(1);
        chk("t3_done_l3", 32'(vld[2]), 32'h0);
        idle(2);

        // Stall holds the response and blocks a new write
        rd(8'd5, 4'hF);
        step(0, 1, 1, 0, 4'hF, 8'd5, 32'h0, 1);
        chk("t4_ready_stall", 32'(rdy[0]), 32'h0);
        chk("t4_valid_hold", 32'(vld[0]), 32'h1);
        step(0, 1, 1, 0, 4'hF, 8'd5, 32'h0, 1);
        chk("t4_data_hold", dout[0], 32'hDEADBEEF);
        chk("t4_addr_hold", 32'(radr[0]), 32'd5);
        idle(1);
        chk("t4_consumed", 32'(vld[0]), 32'h0);
        chk("t4_l2_after", dout[1], 32'hDEADBEEF);
        rd(8'd5, 4'hF);
        chk("t4_write_blocked", dout[0], 32'hDEADBEEF);
        idle(3);

        // Dummy read produces no response
        step(0, 1, 0, 0, 4'hF, 8'd5, 32'h0, 0);
        chk("dummy_no_valid", 32'(vld[0]), 32'h0);
        idle(3);

        // Reset mid-flight
        wr(8'd7, 32'h5A5A1234, 4'hF);
        rd(8'd7, 4'hF);
        step(1, 0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        chk("t5_l1_cleared", 32'(vld[0]), 32'h0);
        chk("t5_l2_never", 32'(vld[1]), 32'h0);
        idle(1);
        chk("t5_l3_never", 32'(vld[2]), 32'h0);
        idle(1);
        rd(8'd7, 4'hF);
        chk("t5_write_kept", dout[0], 32'h5A5A1234);
        idle(3);

        // Out-of-range access on the depth-200 instance
        wr(8'd210, 32'hCAFEF00D, 4'hF);
`ifdef DMEM_ERR_EN
        chk("t6_wr_err_pulse", 32'(errv[2]), 32'h1);
        chk("t6_wr_err_inrange", 32'(errv[0]), 32'h0);
`endif
        idle(1);
        rd(8'd210, 4'hF);
        chk("t6_inrange_l1", dout[0], 32'hCAFEF00D);
        idle(2);
        chk("t6_oor_valid", 32'(vld[2]), 32'h1);
        chk("t6_oor_data", dout[2], 32'h0);
        chk("t6_oor_addr", 32'(radr[2]), 32'd210);
`ifdef DMEM_ERR_EN
        chk("t6_rd_err", 32'(errv[2]), 32'h1);
`endif
        idle(2);
        wr(8'd199, 32'h0BADC0DE, 4'hF);
        rd(8'd199, 4'hF);
        idle(2);
        chk("t6_top_inrange_l3", dout[2], 32'h0BADC0DE);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
